// File: rtl/moxie_wb_pkg.sv
// ---------------------------------------------------------------------------
// moxie_wb_pkg
//   Shared Wishbone definitions for the boot copier: bus widths, the
//   "all byte lanes" select value and the copier state encoding.
// ---------------------------------------------------------------------------
package moxie_wb_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_HW_W  = 16;

    localparam logic [1:0] WB_SEL_ALL = 2'b11;

    // ST_ERR is only ever reached when the ack timeout is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } copy_state_e;

endpackage

// File: rtl/wb_ack_timer.sv
// ---------------------------------------------------------------------------
// wb_ack_timer
//   Counts cycles spent waiting for a Wishbone acknowledge and flags expiry
//   on the TIMEOUT-th consecutive wait cycle. Only used when the copier is
//   built with BOOTCOPY_TIMEOUT_EN.
// Ports
//   clk_i      in  1  clock
//   rst_i      in  1  asynchronous reset, active high
//   clr_i      in  1  restart the count (ack seen, or no access pending)
//   en_i       in  1  an access is pending this cycle
//   expired_o  out 1  this is the TIMEOUT-th wait cycle without ack
// ---------------------------------------------------------------------------
module wb_ack_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of wait cycles already elapsed, so the current
    // cycle is wait cycle cnt_q+1.
    assign expired_o = en_i && !clr_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_boot_copier.sv
// ---------------------------------------------------------------------------
// wb_boot_copier
//   Wishbone initiator that copies LEN_HW 16-bit halfwords from SRC_BASE to
//   DST_BASE after a start pulse, using classic single cycles alternating
//   read / write with cyc/stb held high for the whole copy.
//   Optional feature macro: BOOTCOPY_TIMEOUT_EN (ack timeout -> ERR state).
// Ports
//   wb_clk_i   in  1   clock
//   wb_rst_i   in  1   asynchronous reset, active high
//   start_i    in  1   copy request pulse (accepted in IDLE/DONE/ERR only)
//   busy_o     out 1   copy in progress
//   done_o     out 1   copy finished or aborted, sticky until next start
//   err_o      out 1   copy aborted on ack timeout, sticky until next start
//   wb_adr_o   out 32  byte address (bit 0 always 0)
//   wb_dat_o   out 32  write data {16'h0000, halfword}
//   wb_dat_i   in  32  read data, halfword in [15:0]
//   wb_we_o    out 1   write enable
//   wb_tga_o   out 1   address tag, always 0 (memory space)
//   wb_stb_o   out 1   strobe
//   wb_cyc_o   out 1   cycle
//   wb_sel_o   out 2   byte lanes
//   wb_ack_i   in  1   slave acknowledge (may be combinational)
// ---------------------------------------------------------------------------
module wb_boot_copier
    import moxie_wb_pkg::*;
#(
    parameter logic [WB_ADR_W-1:0] SRC_BASE = 32'h0000_1000,
    parameter logic [WB_ADR_W-1:0] DST_BASE = 32'h0000_0000,
    parameter int unsigned         LEN_HW   = 128,
    parameter int unsigned         TIMEOUT  = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    output logic                wb_we_o,
    output logic                wb_tga_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    output logic [1:0]          wb_sel_o,
    input  logic                wb_ack_i
);

    localparam logic [WB_HW_W-1:0] LAST_IDX = WB_HW_W'(LEN_HW - 1);

    // Elaboration-time parameter sanity checks.
    if (LEN_HW < 1 || LEN_HW > 65535) begin : g_bad_len
        $error("wb_boot_copier: LEN_HW out of range 1..65535");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("wb_boot_copier: TIMEOUT must be at least 2");
    end

    copy_state_e         state_q, state_d;
    logic [WB_HW_W-1:0]  idx_q, idx_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic                we_q, we_d;
    logic                stb_q, stb_d;
    logic                cyc_q, cyc_d;
    logic [1:0]          sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ack;
    logic                ack_timeout;
    logic                unused_dat_hi;

    // Only the low halfword of the read data is copied.
    assign unused_dat_hi = ^wb_dat_i[WB_DAT_W-1:WB_HW_W];

    // An ack outside an active strobe is not ours.
    assign ack = wb_ack_i && stb_q;

`ifdef BOOTCOPY_TIMEOUT_EN
    logic err_q, err_d;

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clr_i     (ack || !stb_q),
        .en_i      (stb_q),
        .expired_o (ack_timeout)
    );
`else
    assign ack_timeout = 1'b0;
`endif

    // Next state, copy index and latched read halfword.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_RD;
                    idx_d   = '0;
                end
            end
            ST_RD: begin
                if (ack) begin
                    state_d = ST_WR;
                    dat_d   = {{(WB_DAT_W-WB_HW_W){1'b0}}, wb_dat_i[WB_HW_W-1:0]};
                end else if (ack_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_WR: begin
                if (ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (ack_timeout) begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The write data register doubles as the halfword latch, so it is
        // only meaningful while a write is being presented.
        if (state_d != ST_WR) begin
            dat_d = '0;
        end
    end

    // Registered bus outputs decoded from the upcoming state, so the bus
    // reflects the new phase in the very cycle after an ack.
    always_comb begin
        stb_d  = (state_d == ST_RD) || (state_d == ST_WR);
        cyc_d  = stb_d;
        busy_d = stb_d;
        we_d   = (state_d == ST_WR);
        sel_d  = stb_d ? WB_SEL_ALL : 2'b00;
        adr_d  = '0;
        if (state_d == ST_RD) begin
            adr_d = SRC_BASE + WB_ADR_W'({idx_d, 1'b0});
        end else if (state_d == ST_WR) begin
            adr_d = DST_BASE + WB_ADR_W'({idx_d, 1'b0});
        end
        adr_d[0] = 1'b0;
        done_d = (state_d == ST_DONE) || (state_d == ST_ERR);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            sel_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BOOTCOPY_TIMEOUT_EN
    assign err_d = (state_d == ST_ERR);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_tga_o = 1'b0;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = cyc_q;
    assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_wb_boot_copier.sv
// ---------------------------------------------------------------------------
// tb_wb_boot_copier
//   Scoreboard bench for wb_boot_copier. Instance u_dut copies 4 halfwords
//   from 0x1000 to 0x0; instance u_wrap copies 4 halfwords from 0xFFFF_FFFC
//   to 0x100 to exercise address wrap. Timeout test runs only when
//   BOOTCOPY_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_wb_boot_copier;

    localparam logic [31:0] SRC   = 32'h0000_1000;
    localparam logic [31:0] DST   = 32'h0000_0000;
    localparam logic [31:0] SRC2  = 32'hFFFF_FFFC;
    localparam logic [31:0] DST2  = 32'h0000_0100;
    localparam int          LEN   = 4;
    localparam int          TMO   = 16;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xact_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2;
    logic        busy, done, err, we, tga, stb, cyc, ack;
    logic [31:0] adr, dat_o, dat_i;
    logic [1:0]  sel;
    logic        busy2, done2, err2, we2, tga2, stb2, cyc2, ack2;
    logic [31:0] adr2, dat_o2, dat_i2;
    logic [1:0]  sel2;

    int total = 0;
    int bad   = 0;

    xact_t exp_q[$];
    xact_t exp2_q[$];

    logic [15:0] rom [0:3];
    logic [15:0] ram [0:3];
    int          n_wr [0:3];
    int          waits    = 0;
    int          wcnt     = 0;
    int          hang_idx = -1;

    wb_boot_copier #(
        .SRC_BASE (SRC), .DST_BASE (DST), .LEN_HW (LEN), .TIMEOUT (TMO)
    ) u_dut (
        .wb_clk_i (clk),   .wb_rst_i (rst),   .start_i  (start),
        .busy_o   (busy),  .done_o   (done),  .err_o    (err),
        .wb_adr_o (adr),   .wb_dat_o (dat_o), .wb_dat_i (dat_i),
        .wb_we_o  (we),    .wb_tga_o (tga),   .wb_stb_o (stb),
        .wb_cyc_o (cyc),   .wb_sel_o (sel),   .wb_ack_i (ack)
    );

    wb_boot_copier #(
        .SRC_BASE (SRC2), .DST_BASE (DST2), .LEN_HW (LEN), .TIMEOUT (TMO)
    ) u_wrap (
        .wb_clk_i (clk),   .wb_rst_i (rst),    .start_i  (start2),
        .busy_o   (busy2), .done_o   (done2),  .err_o    (err2),
        .wb_adr_o (adr2),  .wb_dat_o (dat_o2), .wb_dat_i (dat_i2),
        .wb_we_o  (we2),   .wb_tga_o (tga2),   .wb_stb_o (stb2),
        .wb_cyc_o (cyc2),  .wb_sel_o (sel2),   .wb_ack_i (ack2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- slave models ----------------
    assign dat_i  = {16'hDEAD, rom[adr[2:1]]};
    assign dat_i2 = {16'hBEEF, adr2[15:0] ^ 16'h5A5A};
    assign ack2   = cyc2 && stb2;

    always_comb begin
        ack = 1'b0;
        if (cyc && stb && wcnt == waits) ack = 1'b1;
        if (hang_idx >= 0 && !we && adr == SRC + 32'(2 * hang_idx)) ack = 1'b0;
    end

    always @(posedge clk) begin
        if (cyc && stb && !ack) wcnt <= wcnt + 1;
        else                    wcnt <= 0;
    end

    // ---------------- monitors / scoreboard ----------------
    logic        prev_wait = 1'b0;
    logic [31:0] prev_adr, prev_dat;
    logic        prev_we;

    always @(negedge clk) begin
        if (rst) begin
            prev_wait = 1'b0;
        end else begin
            if (stb) chk("sel_active", 32'(sel), 32'd3);
            else     chk("sel_idle", 32'(sel), 32'd0);
            if (prev_wait) begin
                chk("hold_adr", adr, prev_adr);
                chk("hold_we", 32'(we), 32'(prev_we));
                chk("hold_dat", dat_o, prev_dat);
            end
            if (cyc && stb && ack) begin
                $display("xact we=%0d adr=%h dat_o=%h dat_i=%h", we, adr, dat_o, dat_i);
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    xact_t e;
                    e = exp_q.pop_front();
                    chk("xact_we", 32'(we), 32'(e.we));
                    chk("xact_adr", adr, e.adr);
                    if (we) begin
                        chk("xact_dat", dat_o, e.dat);
                        ram[adr[2:1]] = dat_o[15:0];
                        n_wr[adr[2:1]]++;
                    end
                end
            end
            prev_wait = cyc && stb && !ack;
            prev_adr  = adr;
            prev_we   = we;
            prev_dat  = dat_o;
        end
    end

    always @(negedge clk) begin
        if (!rst && cyc2 && stb2 && ack2) begin
            $display("xact2 we=%0d adr=%h dat_o=%h", we2, adr2, dat_o2);
            if (exp2_q.size() == 0) begin
                chk("sb2_underflow", 32'(exp2_q.size()), 32'd1);
            end else begin
                xact_t e;
                e = exp2_q.pop_front();
                chk("wrap_we", 32'(we2), 32'(e.we));
                chk("wrap_adr", adr2, e.adr);
                if (we2) chk("wrap_dat", dat_o2, e.dat);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_copy();
        for (int i = 0; i < LEN; i++) begin
            exp_q.push_back('{1'b0, SRC + 32'(2 * i), 32'h0});
            exp_q.push_back('{1'b1, DST + 32'(2 * i), {16'h0, rom[i]}});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int bc);
        bit seen;
        seen = 1'b0;
        bc   = 0;
        for (int i = 0; i < 4000; i++) begin
            if (busy) bc++;
            if (done && !busy) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_in_budget", 32'(seen), 32'd1);
    endtask

    task automatic clear_ram();
        for (int i = 0; i < LEN; i++) begin
            ram[i]  = 16'h0;
            n_wr[i] = 0;
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < LEN; i++) chk(tag, 32'(ram[i]), 32'(rom[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int bc;
        bit found;
        logic [31:0] wrap_src [0:3];

        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        clear_ram();
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_adr", adr, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_tga", 32'(tga), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: zero-wait copy
        waits = 0;
        push_copy();
        pulse_start();
        wait_done(bc);
        chk("t1_busy_cycles", 32'(bc), 32'd8);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        check_ram("t1_ram");

        // 2: three wait states per access
        clear_ram();
        waits = 3;
        push_copy();
        pulse_start();
        wait_done(bc);
        chk("t2_busy_cycles", 32'(bc), 32'd32);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        check_ram("t2_ram");

        // 3: start while busy is ignored; start in DONE restarts
        clear_ram();
        waits = 1;
        push_copy();
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_done(bc);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
        check_ram("t3_ram");
        chk("t3_done_held", 32'(done), 32'd1);
        clear_ram();
        push_copy();
        pulse_start();
        chk("t3_done_cleared", 32'(done), 32'd0);
        chk("t3_busy_restart", 32'(busy), 32'd1);
        wait_done(bc);
        chk("t3b_busy_cycles", 32'(bc), 32'd16);
        chk("t3b_sb_empty", 32'(exp_q.size()), 32'd0);
        check_ram("t3b_ram");

        // 4: reset during write of idx 2
        waits = 0;
        push_copy();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (stb && we && adr == DST + 32'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t4_wr2_seen", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t4_cyc_async", 32'(cyc), 32'd0);
        chk("t4_stb_async", 32'(stb), 32'd0);
        chk("t4_we_async", 32'(we), 32'd0);
        chk("t4_busy_async", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_idle_cyc", 32'(cyc), 32'd0);
            chk("t4_idle_busy", 32'(busy), 32'd0);
            chk("t4_idle_done", 32'(done), 32'd0);
        end

`ifdef BOOTCOPY_TIMEOUT_EN
        // 5: slave never acks read of idx 1
        clear_ram();
        hang_idx = 1;
        exp_q.push_back('{1'b0, SRC, 32'h0});
        exp_q.push_back('{1'b1, DST, {16'h0, rom[0]}});
        pulse_start();
        bc = 0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (stb && !we && adr == SRC + 32'd2) bc++;
            if (done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_done_seen", 32'(found), 32'd1);
        chk("t5_wait_cycles", 32'(bc), 32'(TMO));
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cyc", 32'(cyc), 32'd0);
        chk("t5_wr0_count", 32'(n_wr[0]), 32'd1);
        chk("t5_wr1_count", 32'(n_wr[1]), 32'd0);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        hang_idx = -1;
        clear_ram();
        push_copy();
        pulse_start();
        chk("t5_err_cleared", 32'(err), 32'd0);
        wait_done(bc);
        chk("t5b_err", 32'(err), 32'd0);
        check_ram("t5b_ram");
`endif

        // 6: source address wrap on second instance
        wrap_src[0] = 32'hFFFF_FFFC; wrap_src[1] = 32'hFFFF_FFFE;
        wrap_src[2] = 32'h0000_0000; wrap_src[3] = 32'h0000_0002;
        for (int i = 0; i < LEN; i++) begin
            exp2_q.push_back('{1'b0, wrap_src[i], 32'h0});
            exp2_q.push_back('{1'b1, DST2 + 32'(2 * i), {16'h0, wrap_src[i][15:0] ^ 16'h5A5A}});
        end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bc = 0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy2) bc++;
            if (done2 && !busy2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_done_seen", 32'(found), 32'd1);
        chk("t6_busy_cycles", 32'(bc), 32'd8);
        chk("t6_err", 32'(err2), 32'd0);
        chk("t6_sb_empty", 32'(exp2_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
